// File: rtl/ni_packetizer.sv
// NI transmit packetizer: turns local message requests into HEAD/BODY/TAIL
// or SINGLE flits behind a single registered output slot.
module ni_packetizer #(
    parameter int PORT_WIDTH = 128,
    parameter int DEST_W     = 4,
    parameter int LEN_W      = 4,
    parameter int SRC_ID     = 0
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  cmd_val,
    output logic                  cmd_rdy,
    input  logic [DEST_W-1:0]     cmd_dest,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic                  pld_val,
    output logic                  pld_rdy,
    input  logic [PORT_WIDTH-3:0] pld_dat,
    output logic                  flit_val,
    output logic [PORT_WIDTH-1:0] flit_dat,
    input  logic                  flit_rdy,
    output logic                  busy
);

    localparam int PW = PORT_WIDTH;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BODY = 1'b1;
    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    logic [0:0]       state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [7:0]       seq_q, seq_d;
    logic             flit_val_q, flit_val_d;
    logic [PW-1:0]    flit_dat_q, flit_dat_d;

    logic          slot_free;
    logic          cmd_fire;
    logic          pld_fire;
    logic          last_body;
    logic [PW-1:0] hdr;

    assign slot_free = !flit_val_q || flit_rdy;
    assign cmd_rdy   = (state_q == ST_IDLE) && slot_free;
    assign pld_rdy   = (state_q == ST_BODY) && slot_free;
    assign cmd_fire  = cmd_val && cmd_rdy;
    assign pld_fire  = pld_val && pld_rdy;
    assign last_body = (remaining_q == LEN_W'(1));
    assign busy      = (state_q == ST_BODY);
    assign flit_val  = flit_val_q;
    assign flit_dat  = flit_dat_q;

    // Header fields packed from the MSB down; the low bits stay zero.
    always_comb begin
        hdr = '0;
        hdr[PW-1 -: 2] = (cmd_len == '0) ? T_SINGLE : T_HEAD;
        hdr[PW-3 -: DEST_W] = cmd_dest;
        hdr[PW-3-DEST_W -: DEST_W] = DEST_W'(SRC_ID);
        hdr[PW-3-2*DEST_W -: LEN_W] = cmd_len;
        hdr[PW-3-2*DEST_W-LEN_W -: 8] = seq_q;
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        seq_d       = seq_q;
        flit_val_d  = flit_val_q;
        flit_dat_d  = flit_dat_q;
        if (flit_val_q && flit_rdy) begin
            flit_val_d = 1'b0;
        end
        unique case (1'b1)
            cmd_fire: begin
                flit_val_d = 1'b1;
                flit_dat_d = hdr;
                seq_d      = seq_q + 8'd1;
                if (cmd_len != '0) begin
                    state_d     = ST_BODY;
                    remaining_d = cmd_len;
                end
            end
            pld_fire: begin
                flit_val_d  = 1'b1;
                flit_dat_d  = {last_body ? T_TAIL : T_BODY, pld_dat};
                remaining_d = remaining_q - LEN_W'(1);
                if (last_body) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            seq_q       <= '0;
            flit_val_q  <= 1'b0;
            flit_dat_q  <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            seq_q       <= seq_d;
            flit_val_q  <= flit_val_d;
            flit_dat_q  <= flit_dat_d;
        end
    end

endmodule

// File: tb/tb_ni_packetizer.sv
// Self-checking bench for ni_packetizer: vector table, directed corner
// sequences and a randomized run against a packet-level queue model.
module tb_ni_packetizer;

    localparam logic [3:0] SRC = 4'd6;

    logic         clk = 1'b0;
    logic         srst;
    logic         cmd_val;
    logic         cmd_rdy;
    logic [3:0]   cmd_dest;
    logic [3:0]   cmd_len;
    logic         pld_val;
    logic         pld_rdy;
    logic [125:0] pld_dat;
    logic         flit_val;
    logic [127:0] flit_dat;
    logic         flit_rdy;
    logic         busy;

    int checks = 0;
    int failures = 0;

    ni_packetizer #(
        .PORT_WIDTH(128), .DEST_W(4), .LEN_W(4), .SRC_ID(6)
    ) dut (
        .clk(clk), .srst(srst),
        .cmd_val(cmd_val), .cmd_rdy(cmd_rdy),
        .cmd_dest(cmd_dest), .cmd_len(cmd_len),
        .pld_val(pld_val), .pld_rdy(pld_rdy), .pld_dat(pld_dat),
        .flit_val(flit_val), .flit_dat(flit_dat), .flit_rdy(flit_rdy),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] dest;
        logic [3:0] len;
        logic [7:0] seq;
    } vec_t;

    vec_t vt[5];

    logic [127:0] exp_q[$];
    logic [125:0] pld_q[$];
    logic [7:0]   mseq;
    logic         prev_stall;
    logic [128:0] prev_out;

    function automatic logic [127:0] hdr(input logic [1:0] t,
        input logic [3:0] d, input logic [3:0] l, input logic [7:0] s);
        logic [127:0] f;
        f = '0;
        f[127:126] = t;
        f[125:122] = d;
        f[121:118] = SRC;
        f[117:114] = l;
        f[113:106] = s;
        return f;
    endfunction

    function automatic logic [125:0] rnd_pld();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[125:0];
    endfunction

    task automatic chk(input string nm, input logic [128:0] act,
                       input logic [128:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        srst = 1'b1;
        cmd_val = 1'b0;
        cmd_dest = '0;
        cmd_len = '0;
        pld_val = 1'b0;
        pld_dat = '0;
        flit_rdy = 1'b1;
        adv();
        adv();
        srst = 1'b0;
    endtask

    // Packet with flit_rdy held high: one flit per cycle, latency one.
    task automatic run_pkt(input logic [3:0] d, input logic [3:0] l,
                           input logic [7:0] s);
        logic [125:0] w[$];
        flit_rdy = 1'b1;
        cmd_val = 1'b1;
        cmd_dest = d;
        cmd_len = l;
        @(negedge clk);
        chk("pkt_cmd_rdy", cmd_rdy, 1);
        adv();
        cmd_val = 1'b0;
        cmd_dest = ~d;
        cmd_len = ~l;
        for (int i = 0; i <= int'(l); i++) begin
            if (i < int'(l)) begin
                w.push_back(rnd_pld());
                pld_val = 1'b1;
                pld_dat = w[i];
            end else begin
                pld_val = 1'b0;
            end
            @(negedge clk);
            if (i == 0)
                chk("pkt_hdr", {flit_val, flit_dat},
                    {1'b1, hdr((l == 0) ? 2'b11 : 2'b01, d, l, s)});
            else
                chk("pkt_body", {flit_val, flit_dat},
                    {1'b1, (i == int'(l)) ? 2'b10 : 2'b00, w[i-1]});
            chk("pkt_busy", busy, (i < int'(l)) ? 1 : 0);
            if (i < int'(l))
                chk("pkt_pld_rdy", pld_rdy, 1);
            adv();
        end
        pld_val = 1'b0;
    endtask

    task automatic rand_cycle(input bit gen);
        int l;
        logic [125:0] w;
        flit_rdy = ($urandom % 4) != 0;
        cmd_val = gen && (($urandom % 3) == 0);
        cmd_dest = 4'($urandom);
        cmd_len = (($urandom % 4) == 0) ? 4'd15 : 4'($urandom % 6);
        if (pld_q.size() != 0) begin
            pld_val = gen ? (($urandom % 4) != 0) : 1'b1;
            pld_dat = pld_q[0];
        end else begin
            pld_val = 1'($urandom);
            pld_dat = rnd_pld();
        end
        @(negedge clk);
        if (prev_stall)
            chk("rand_hold", {flit_val, flit_dat}, prev_out);
        if (pld_q.size() == 0)
            chk("rand_pld_rdy_idle", pld_rdy, 0);
        else
            chk("rand_cmd_rdy_body", cmd_rdy, 0);
        if (flit_val && flit_rdy) begin
            if (exp_q.size() == 0)
                chk("rand_extra_flit", {1'b1, flit_dat}, 0);
            else
                chk("rand_flit", flit_dat, exp_q.pop_front());
        end
        if (pld_val && pld_rdy && pld_q.size() != 0)
            void'(pld_q.pop_front());
        if (cmd_val && cmd_rdy) begin
            l = int'(cmd_len);
            exp_q.push_back(hdr((l == 0) ? 2'b11 : 2'b01,
                                cmd_dest, cmd_len, mseq));
            mseq = mseq + 8'd1;
            for (int j = 0; j < l; j++) begin
                w = rnd_pld();
                pld_q.push_back(w);
                exp_q.push_back({(j == l - 1) ? 2'b10 : 2'b00, w});
            end
        end
        prev_stall = flit_val && !flit_rdy;
        prev_out = {flit_val, flit_dat};
        adv();
    endtask

    initial begin
        logic [125:0] a, b, c;
        int guard;
        vt[0] = '{dest: 4'd3,  len: 4'd0,  seq: 8'd0};
        vt[1] = '{dest: 4'd5,  len: 4'd3,  seq: 8'd1};
        vt[2] = '{dest: 4'd9,  len: 4'd1,  seq: 8'd2};
        vt[3] = '{dest: 4'd15, len: 4'd15, seq: 8'd3};
        vt[4] = '{dest: 4'd0,  len: 4'd2,  seq: 8'd4};

        do_reset();
        flit_rdy = 1'b0;
        @(negedge clk);
        chk("rst_flit", {flit_val, flit_dat}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_rdy", cmd_rdy, 1);
        chk("rst_pld_rdy", pld_rdy, 0);
        adv();

        for (int i = 0; i < 5; i++)
            run_pkt(vt[i].dest, vt[i].len, vt[i].seq);

        // Stall mid-packet: slot full blocks payload and commands.
        do_reset();
        a = rnd_pld(); b = rnd_pld(); c = rnd_pld();
        cmd_val = 1'b1; cmd_dest = 4'd5; cmd_len = 4'd3;
        adv();
        cmd_val = 1'b0; pld_val = 1'b1; pld_dat = a;
        @(negedge clk);
        chk("st_hdr", {flit_val, flit_dat}, {1'b1, hdr(2'b01, 4'd5, 4'd3, 8'd0)});
        adv();
        pld_dat = b; flit_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("st_hold", {flit_val, flit_dat}, {1'b1, 2'b00, a});
            chk("st_pld_rdy", pld_rdy, 0);
            chk("st_cmd_rdy", cmd_rdy, 0);
            adv();
        end
        flit_rdy = 1'b1;
        @(negedge clk);
        chk("st_a", {flit_val, flit_dat}, {1'b1, 2'b00, a});
        adv();
        pld_dat = c;
        @(negedge clk);
        chk("st_b", {flit_val, flit_dat}, {1'b1, 2'b00, b});
        adv();
        pld_val = 1'b0; flit_rdy = 1'b0; cmd_val = 1'b1;
        @(negedge clk);
        chk("st_tail", {flit_val, flit_dat}, {1'b1, 2'b10, c});
        chk("st_idle_full", cmd_rdy, 0);
        adv();
        flit_rdy = 1'b1; cmd_val = 1'b0;
        adv();
        @(negedge clk);
        chk("st_drained", {flit_val, busy}, 0);
        adv();

        // Back-to-back len=1 packets.
        do_reset();
        a = rnd_pld(); b = rnd_pld();
        cmd_val = 1'b1; cmd_dest = 4'd7; cmd_len = 4'd1;
        adv();
        cmd_dest = 4'd8; pld_val = 1'b1; pld_dat = a;
        @(negedge clk);
        chk("bb_h0", {flit_val, flit_dat}, {1'b1, hdr(2'b01, 4'd7, 4'd1, 8'd0)});
        chk("bb_cmd_blk", cmd_rdy, 0);
        adv();
        pld_val = 1'b0;
        @(negedge clk);
        chk("bb_t0", {flit_val, flit_dat}, {1'b1, 2'b10, a});
        chk("bb_cmd_rdy", cmd_rdy, 1);
        adv();
        cmd_val = 1'b0; pld_val = 1'b1; pld_dat = b;
        @(negedge clk);
        chk("bb_h1", {flit_val, flit_dat}, {1'b1, hdr(2'b01, 4'd8, 4'd1, 8'd1)});
        adv();
        pld_val = 1'b0;
        @(negedge clk);
        chk("bb_t1", {flit_val, flit_dat}, {1'b1, 2'b10, b});
        adv();

        // 257 single-flit packets: sequence wraps after 255.
        do_reset();
        cmd_val = 1'b1; cmd_dest = 4'd2; cmd_len = 4'd0;
        for (int k = 0; k <= 257; k++) begin
            if (k == 257) cmd_val = 1'b0;
            @(negedge clk);
            if (k > 0)
                chk("wrap_seq", {flit_val, flit_dat},
                    {1'b1, hdr(2'b11, 4'd2, 4'd0, 8'((k - 1) % 256))});
            adv();
        end

        // Reset mid-packet wins over a simultaneous payload handshake.
        do_reset();
        a = rnd_pld(); b = rnd_pld();
        cmd_val = 1'b1; cmd_dest = 4'd4; cmd_len = 4'd15;
        adv();
        cmd_val = 1'b0; pld_val = 1'b1; pld_dat = a;
        adv();
        pld_dat = b;
        adv();
        pld_dat = rnd_pld(); srst = 1'b1;
        @(negedge clk);
        chk("sr_b", {flit_val, flit_dat}, {1'b1, 2'b00, b});
        adv();
        srst = 1'b0; pld_val = 1'b0;
        @(negedge clk);
        chk("sr_flit", {flit_val, flit_dat}, 0);
        chk("sr_busy", busy, 0);
        chk("sr_cmd_rdy", cmd_rdy, 1);
        chk("sr_pld_rdy", pld_rdy, 0);
        adv();
        run_pkt(4'd2, 4'd0, 8'd0);

        // Randomized traffic against the queue model.
        do_reset();
        mseq = 8'd0;
        prev_stall = 1'b0;
        prev_out = '0;
        exp_q.delete();
        pld_q.delete();
        for (int k = 0; k < 1500; k++)
            rand_cycle(1'b1);
        guard = 0;
        while ((exp_q.size() != 0 || pld_q.size() != 0) && guard < 300) begin
            rand_cycle(1'b0);
            guard++;
        end
        chk("rand_drain", 129'(exp_q.size() + pld_q.size()), 0);
        cmd_val = 1'b0; pld_val = 1'b0; flit_rdy = 1'b1;
        adv();
        @(negedge clk);
        chk("rand_final_idle", {flit_val, busy}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
